// File: rtl/stream_resize_pkg.sv
// Shared helpers for the stream width converters.
// Mask helpers take a fixed-width mask so they are usable from any
// lane count up to LANE_MASK_MAX; callers zero-extend their mask.
package stream_resize_pkg;

   localparam int LANE_MASK_MAX = 64;

   typedef logic [LANE_MASK_MAX-1:0] lane_mask_t;

   // True when at most one bit of the mask is set (zero counts as true).
   function automatic logic onehot_or_zero(input lane_mask_t mask);
      return (mask & (mask - lane_mask_t'(1))) == '0;
   endfunction

   // True when exactly one bit is set, without a popcount.
   function automatic logic single_bit(input lane_mask_t mask);
      return (mask != '0) && onehot_or_zero(mask);
   endfunction

endpackage

// File: rtl/stream_lane_pick.sv
// Combinational lane priority encoder: picks the next pending lane of a
// mask and produces the one-hot mask that retires it.
// STREAM_RESIZE_MSB_FIRST_EN: pick the highest set lane instead of the lowest.
// With an all-zero mask, sel is 0 and clr is all-zero.
module stream_lane_pick #(
   parameter int N     = 4,
   parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     mask,
   output logic [SEL_W-1:0] sel,
   output logic [N-1:0]     clr
);

   // Priority scan; the last match in loop order wins.
   always_comb begin
      sel = '0;
`ifdef STREAM_RESIZE_MSB_FIRST_EN
      for (int i = 0; i < N; i++)
         if (mask[i]) sel = SEL_W'(i);
`else
      for (int i = N - 1; i >= 0; i--)
         if (mask[i]) sel = SEL_W'(i);
`endif
   end

   // Masking with the input keeps clr zero when nothing is pending.
   assign clr = mask & (N'(1) << sel);

endmodule

// File: rtl/stream_downsizer_sparse.sv
// Wide-to-narrow stream converter with per-lane keep. Each accepted beat
// is held and its kept lanes are emitted one per output beat; holes in
// the keep mask are skipped. A beat with keep==0 and last set cannot be
// delivered and is reported on err_null_last.
// STREAM_RESIZE_MSB_FIRST_EN: emit lanes from the highest index downward.
module stream_downsizer_sparse
   import stream_resize_pkg::*;
#(
   parameter int T_DATA_WIDTH = 32,
   parameter int T_DATA_RATIO = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [T_DATA_WIDTH-1:0] s_data [T_DATA_RATIO],
   input  logic [T_DATA_RATIO-1:0] s_keep,
   input  logic                    s_last,
   input  logic                    s_valid,
   output logic                    s_ready,
   output logic [T_DATA_WIDTH-1:0] m_data,
   output logic                    m_last,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic                    err_null_last
);

   localparam int SEL_W = (T_DATA_RATIO > 1) ? $clog2(T_DATA_RATIO) : 1;
   typedef logic [SEL_W-1:0] lane_idx_t;

   logic [T_DATA_WIDTH-1:0] data_q [T_DATA_RATIO];
   logic [T_DATA_RATIO-1:0] rem;
   logic                    last_q;

   lane_idx_t               sel;
   logic [T_DATA_RATIO-1:0] clr;
   logic                    rem_final;
   logic                    s_hs;
   logic                    m_hs;

   stream_lane_pick #(
      .N     (T_DATA_RATIO),
      .SEL_W (SEL_W)
   ) u_pick (
      .mask (rem),
      .sel  (sel),
      .clr  (clr)
   );

   // Exactly one lane left: this output beat retires the held beat.
   assign rem_final = single_bit(lane_mask_t'(rem));

   assign m_valid = (rem != '0);
   assign m_data  = data_q[sel];
   assign m_last  = last_q & rem_final;

   // Accept while empty, or while the final lane is leaving this cycle.
   assign s_ready = (rem == '0) | (m_ready & rem_final);

   assign s_hs = s_valid & s_ready;
   assign m_hs = m_valid & m_ready;

   // Holding register: load on input handshake (load beats the clear of
   // the final lane), otherwise retire the emitted lane.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem    <= '0;
         last_q <= 1'b0;
         for (int i = 0; i < T_DATA_RATIO; i++) data_q[i] <= '0;
      end else if (s_hs) begin
         rem    <= s_keep;
         last_q <= s_last;
         for (int i = 0; i < T_DATA_RATIO; i++) data_q[i] <= s_data[i];
      end else if (m_hs) begin
         rem <= rem & ~clr;
      end
   end

   // One-cycle flag for a packet end carried on a beat with no lanes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_null_last <= 1'b0;
      else     err_null_last <= s_hs & (s_keep == '0) & s_last;
   end

endmodule

// File: tb/tb_stream_downsizer_sparse.sv
module tb_stream_downsizer_sparse;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] s_data [4];
   logic [3:0]  s_keep = '0;
   logic        s_last = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [31:0] m_data;
   logic        m_last;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic        err_null_last;

   typedef struct {
      logic [31:0] d;
      logic        l;
   } exp_t;

   exp_t exp_q[$];
   int   hs_cyc[$];
   int   cyc = 0;
   int   in_cyc = 0;
   int   checks = 0;
   int   failures = 0;

   logic        prev_stall = 1'b0;
   logic [31:0] prev_d = '0;
   logic        prev_l = 1'b0;

   stream_downsizer_sparse #(.T_DATA_WIDTH(32), .T_DATA_RATIO(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_data        (s_data),
      .s_keep        (s_keep),
      .s_last        (s_last),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .m_data        (m_data),
      .m_last        (m_last),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .err_null_last (err_null_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected output lanes of one beat, in emission order.
   task automatic push_exp(input logic [31:0] d3, d2, d1, d0, input logic [3:0] k, input logic l);
      logic [31:0] d [4];
      exp_t e;
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
`ifdef STREAM_RESIZE_MSB_FIRST_EN
      for (int i = 3; i >= 0; i--)
         if (k[i]) begin
            e.d = d[i];
            e.l = l && ((k & 4'((1 << i) - 1)) == 4'd0);
            exp_q.push_back(e);
         end
`else
      for (int i = 0; i < 4; i++)
         if (k[i]) begin
            e.d = d[i];
            e.l = l && ((k >> (i + 1)) == 4'd0);
            exp_q.push_back(e);
         end
`endif
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [31:0] d3, d2, d1, d0, input logic [3:0] k, input logic l);
      int n = 0;
      push_exp(d3, d2, d1, d0, k, l);
      s_data[0] = d0; s_data[1] = d1; s_data[2] = d2; s_data[3] = d3;
      s_keep = k; s_last = l; s_valid = 1'b1;
      @(negedge clk);
      while (!s_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) check("send_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      in_cyc = cyc;
      s_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("drain_left", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   // Output monitor: scoreboard pop on handshake, stability under stall.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", 64'(m_valid), 64'd1);
            check("hold_data", 64'(m_data), 64'(prev_d));
            check("hold_last", 64'(m_last), 64'(prev_l));
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 64'(m_data), 64'hdead);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("out_data", 64'(m_data), 64'(e.d));
               check("out_last", 64'(m_last), 64'(e.l));
            end
            hs_cyc.push_back(cyc + 1);
         end
         prev_stall = m_valid && !m_ready;
         prev_d = m_data;
         prev_l = m_last;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4; i++) s_data[i] = '0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_s_ready", 64'(s_ready), 64'd1);
      check("rst_m_last", 64'(m_last), 64'd0);
      check("rst_m_data", 64'(m_data), 64'd0);
      check("rst_err", 64'(err_null_last), 64'd0);
      @(posedge clk);
      #1;

      // Full beat, no backpressure.
      m_ready = 1'b1;
      hs_cyc.delete();
      send(32'd4, 32'd3, 32'd2, 32'd1, 4'b1111, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("full_valid", 64'(m_valid), 64'd1);
         check("full_s_ready", 64'(s_ready), 64'(i == 3));
      end
      @(negedge clk);
      check("full_idle", 64'(m_valid), 64'd0);
      check("full_count", 64'(hs_cyc.size()), 64'd4);
      if (hs_cyc.size() == 4) check("full_span", 64'(hs_cyc[3] - in_cyc), 64'd4);
      @(posedge clk);
      #1;

      // Sparse beat followed by single-lane beat, no bubble between them.
      hs_cyc.delete();
      send(32'hd, 32'hc, 32'hb, 32'ha, 4'b1010, 1'b0);
      send(32'h0, 32'h0, 32'h0, 32'h5, 4'b0001, 1'b1);
      drain();
      check("sparse_count", 64'(hs_cyc.size()), 64'd3);
      if (hs_cyc.size() == 3) check("sparse_nobubble", 64'(hs_cyc[2] - hs_cyc[0]), 64'd2);

      // Backpressure: ready toggles every cycle.
      m_ready = 1'b0;
      hs_cyc.delete();
      send(32'd4, 32'd3, 32'd2, 32'd1, 4'b1111, 1'b1);
      for (int c = 1; c <= 8; c++) begin
         m_ready = (c % 2 == 0);
         @(negedge clk);
         check("bp_s_ready", 64'(s_ready), 64'(c == 8));
         @(posedge clk);
         #1;
      end
      m_ready = 1'b1;
      check("bp_count", 64'(hs_cyc.size()), 64'd4);
      if (hs_cyc.size() == 4) check("bp_span", 64'(hs_cyc[3] - in_cyc), 64'd8);
      check("bp_idle", 64'(m_valid), 64'd0);

      // Null beats.
      send(32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b1);
      @(negedge clk);
      check("null_last_err", 64'(err_null_last), 64'd1);
      check("null_last_valid", 64'(m_valid), 64'd0);
      @(negedge clk);
      check("null_err_pulse", 64'(err_null_last), 64'd0);
      @(posedge clk);
      #1;
      send(32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("null_drop_err", 64'(err_null_last), 64'd0);
         check("null_drop_valid", 64'(m_valid), 64'd0);
      end
      @(posedge clk);
      #1;
      send(32'h44, 32'h33, 32'h22, 32'h11, 4'b0011, 1'b1);
      drain();

      // Reset in the middle of a beat.
      send(32'd4, 32'd3, 32'd2, 32'd1, 4'b1111, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_valid", 64'(m_valid), 64'd0);
      exp_q.delete();
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("postrst_s_ready", 64'(s_ready), 64'd1);
      check("postrst_valid", 64'(m_valid), 64'd0);
      check("postrst_data", 64'(m_data), 64'd0);
      @(posedge clk);
      #1;
      send(32'd8, 32'd7, 32'd6, 32'd5, 4'b1111, 1'b1);
      drain();

      // Mask with a hole; order depends on build.
      hs_cyc.delete();
      send(32'd4, 32'd3, 32'd2, 32'd1, 4'b1011, 1'b1);
      drain();
      check("hole_count", 64'(hs_cyc.size()), 64'd3);

      check("final_queue", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
